// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the branch prediction unit.
// Contents: branch type codes, 2-bit counter encodings, sequential-PC helper.
package branch_predict_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned BR_TYPE_W = 3;
  localparam int unsigned CTR_W     = 2;

  typedef enum logic [BR_TYPE_W-1:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Fall-through PC of a 4-byte instruction.
  function automatic logic [XLEN-1:0] pc_next_seq(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-side bundle of the branch prediction unit.
// master: CPU pipeline (drives fetch PC and the EX resolve fields).
// slave : predictor (returns prediction, mispredict/redirect, statistics).
interface branch_predict_unit_if #(
  parameter int unsigned CNT_W = 32
);
  import branch_predict_unit_pkg::*;

  // Fetch-stage lookup
  logic [XLEN-1:0]  PCF;
  logic             PredTakenF;
  logic [XLEN-1:0]  PredTargetF;

  // EX-stage resolve
  logic             ValidE;
  logic             StallE;
  br_type_e         BranchTypeE;
  logic             BranchE;
  logic [XLEN-1:0]  PCE;
  logic [XLEN-1:0]  BrTargetE;
  logic             PredTakenE;
  logic [XLEN-1:0]  PredTargetE;
  logic             MispredE;
  logic [XLEN-1:0]  RedirectPCE;

  // Statistics
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] MispredCnt;

  modport master (
    output PCF, ValidE, StallE, BranchTypeE, BranchE, PCE, BrTargetE,
           PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredE, RedirectPCE, BranchCnt, MispredCnt
  );

  modport slave (
    input  PCF, ValidE, StallE, BranchTypeE, BranchE, PCE, BrTargetE,
           PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredE, RedirectPCE, BranchCnt, MispredCnt
  );

endinterface

// File: rtl/branch_predict_unit_btb_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
// Ports: ctr_i current counter, taken_i resolved outcome, ctr_nxt_c next value.
module btb_sat_counter
  import branch_predict_unit_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_nxt_c
);

  // Saturate at strongly-taken / strongly-not-taken.
  always_comb begin
    ctr_nxt_c = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_ST) ctr_nxt_c = ctr_i + CTR_W'(1);
    end else begin
      if (ctr_i != CTR_SNT) ctr_nxt_c = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: fetch-stage prediction, EX-stage
// mispredict detection / redirect, table training and branch statistics.
// Ports: CPU_CLK, CPU_RST (sync, active-high), bus (slave side of
// branch_predict_unit_if: PCF/PredTakenF/PredTargetF lookup, EX resolve
// fields, MispredE/RedirectPCE, BranchCnt/MispredCnt).
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   CPU_CLK,
  input  logic                   CPU_RST,
  branch_predict_unit_if.slave   bus
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = XLEN - IDX_W - 2;

  // Table storage
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Fetch lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;
  logic             pred_taken_f_c;

  assign idx_f          = bus.PCF[IDX_W+1:2];
  assign tag_f          = bus.PCF[XLEN-1:IDX_W+2];
  assign hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f_c = hit_f && ctr_q[idx_f][1];

  assign bus.PredTakenF  = pred_taken_f_c;
  assign bus.PredTargetF = pred_taken_f_c ? target_q[idx_f] : pc_next_seq(bus.PCF);

  // EX resolve
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             hit_e;
  logic             br_e;
  logic             mispred_c;
  logic [XLEN-1:0]  redirect_pc_c;
  ctr_t             ctr_upd_c;

  assign idx_e = bus.PCE[IDX_W+1:2];
  assign tag_e = bus.PCE[XLEN-1:IDX_W+2];
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // Reset masks the resolve so nothing is flagged, counted or trained.
  assign br_e = bus.ValidE && (bus.BranchTypeE != NOBRANCH) && !bus.StallE && !CPU_RST;

  // Mispredict: wrong direction, or taken with a stale predicted target.
  always_comb begin
    mispred_c     = 1'b0;
    redirect_pc_c = pc_next_seq(bus.PCE);
    if (br_e) begin
      if (bus.BranchE) begin
        if (!bus.PredTakenE || (bus.PredTargetE != bus.BrTargetE)) begin
          mispred_c     = 1'b1;
          redirect_pc_c = bus.BrTargetE;
        end
      end else if (bus.PredTakenE) begin
        mispred_c = 1'b1;
      end
    end
  end

  assign bus.MispredE    = mispred_c;
  assign bus.RedirectPCE = redirect_pc_c;

  btb_sat_counter u_sat_counter (
    .ctr_i     (ctr_q[idx_e]),
    .taken_i   (bus.BranchE),
    .ctr_nxt_c (ctr_upd_c)
  );

  // Training write: update on hit, allocate on taken miss, skip not-taken miss.
  logic             wr_en;
  logic [TAG_W-1:0] wr_tag;
  logic [XLEN-1:0]  wr_target;
  ctr_t             wr_ctr;

  always_comb begin
    wr_en     = 1'b0;
    wr_tag    = tag_e;
    wr_target = target_q[idx_e];
    wr_ctr    = ctr_q[idx_e];
    if (br_e) begin
      if (hit_e) begin
        wr_en  = 1'b1;
        wr_ctr = ctr_upd_c;
        if (bus.BranchE) wr_target = bus.BrTargetE;
      end else if (bus.BranchE) begin
        wr_en     = 1'b1;
        wr_target = bus.BrTargetE;
        wr_ctr    = CTR_WT;
      end
    end
  end

  // Statistics next-state (wraps naturally)
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (br_e) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispred_c) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  // Valid bits and counters: cleared by reset.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (wr_en) valid_q[idx_e] <= 1'b1;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Entry payload: meaningless while invalid, so no reset needed.
  always_ff @(posedge CPU_CLK) begin
    if (wr_en) begin
      tag_q[idx_e]    <= wr_tag;
      target_q[idx_e] <= wr_target;
      ctr_q[idx_e]    <= wr_ctr;
    end
  end

  assign bus.BranchCnt  = branch_cnt_q;
  assign bus.MispredCnt = mispred_cnt_q;

  // Instruction-aligned PCs: the low two bits carry no index/tag information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.PCF[1:0], bus.PCE[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus a
// randomized run against a behavioural BTB model.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic CPU_CLK = 1'b0;
  logic CPU_RST = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;

  branch_predict_unit_if #(.CNT_W(32)) bus ();

  branch_predict_unit #(.IDX_W(6), .CNT_W(32)) dut (
    .CPU_CLK (CPU_CLK),
    .CPU_RST (CPU_RST),
    .bus     (bus)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Behavioural model: 64 entries, integer counter 0..3
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic [31:0] m_bcnt, m_mcnt;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc >> 8;
  endfunction

  task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i  = midx(pc);
    tk = m_valid[i] && (m_tag[i] == mtag(pc)) && (m_ctr[i] >= 2);
    tg = tk ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_ex(output logic br, output logic mis, output logic [31:0] redir);
    br    = bus.ValidE && (bus.BranchTypeE != NOBRANCH) && !bus.StallE && !CPU_RST;
    mis   = 1'b0;
    redir = bus.PCE + 32'd4;
    if (br && bus.BranchE && (!bus.PredTakenE || bus.PredTargetE != bus.BrTargetE)) begin
      mis   = 1'b1;
      redir = bus.BrTargetE;
    end
    if (br && !bus.BranchE && bus.PredTakenE) mis = 1'b1;
  endtask

  // Applies the effect of the current edge to the model.
  task automatic model_commit();
    logic br, mis;
    logic [31:0] rd;
    int i;
    bit hit;
    if (CPU_RST) begin
      for (int k = 0; k < 64; k++) m_valid[k] = 0;
      m_bcnt = 0;
      m_mcnt = 0;
      return;
    end
    model_ex(br, mis, rd);
    if (!br) return;
    m_bcnt = m_bcnt + 1;
    if (mis) m_mcnt = m_mcnt + 1;
    i   = midx(bus.PCE);
    hit = m_valid[i] && (m_tag[i] == mtag(bus.PCE));
    if (hit) begin
      if (bus.BranchE) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = bus.BrTargetE;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (bus.BranchE) begin
      m_valid[i] = 1;
      m_tag[i]   = mtag(bus.PCE);
      m_tgt[i]   = bus.BrTargetE;
      m_ctr[i]   = 2;
    end
  endtask

  task automatic tick();
    @(posedge CPU_CLK);
    model_commit();
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input br_type_e ty, input logic b,
                       input logic [31:0] pce, input logic [31:0] bt,
                       input logic pt, input logic [31:0] ptg);
    bus.ValidE      = v;
    bus.StallE      = st;
    bus.BranchTypeE = ty;
    bus.BranchE     = b;
    bus.PCE         = pce;
    bus.BrTargetE   = bt;
    bus.PredTakenE  = pt;
    bus.PredTargetE = ptg;
  endtask

  task automatic idle_ex();
    drive(1'b0, 1'b0, NOBRANCH, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Resolve a branch carrying the model's own prediction, then return to idle.
  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] bt);
    logic tk;
    logic [31:0] tg;
    model_predict(pc, tk, tg);
    drive(1'b1, 1'b0, BEQ, taken, pc, bt, tk, tg);
    tick();
    idle_ex();
  endtask

  task automatic test_reset();
    CPU_RST = 1'b1;
    idle_ex();
    bus.PCF = 32'h0;
    tick();
    tick();
    CPU_RST = 1'b0;
    bus.PCF = 32'h0000_0040;
    #1;
    n_cmp++; if (bus.PredTakenF !== 1'b0) begin n_err++; $display("FAIL reset_taken got %0b want 0", bus.PredTakenF); end
    n_cmp++; if (bus.PredTargetF !== 32'h44) begin n_err++; $display("FAIL reset_target got %h want 00000044", bus.PredTargetF); end
    n_cmp++; if (bus.BranchCnt !== 32'd0) begin n_err++; $display("FAIL reset_bcnt got %0d want 0", bus.BranchCnt); end
    n_cmp++; if (bus.MispredCnt !== 32'd0) begin n_err++; $display("FAIL reset_mcnt got %0d want 0", bus.MispredCnt); end
  endtask

  task automatic test_first_taken();
    bus.PCF = 32'h40;
    drive(1'b1, 1'b0, BEQ, 1'b1, 32'h40, 32'h80, 1'b0, 32'h44);
    #1;
    n_cmp++; if (bus.MispredE !== 1'b1) begin n_err++; $display("FAIL first_mispred got %0b want 1", bus.MispredE); end
    n_cmp++; if (bus.RedirectPCE !== 32'h80) begin n_err++; $display("FAIL first_redirect got %h want 00000080", bus.RedirectPCE); end
    tick();
    idle_ex();
    #1;
    n_cmp++; if (bus.PredTakenF !== 1'b1) begin n_err++; $display("FAIL first_pred got %0b want 1", bus.PredTakenF); end
    n_cmp++; if (bus.PredTargetF !== 32'h80) begin n_err++; $display("FAIL first_target got %h want 00000080", bus.PredTargetF); end
    n_cmp++; if (bus.BranchCnt !== 32'd1) begin n_err++; $display("FAIL first_bcnt got %0d want 1", bus.BranchCnt); end
    n_cmp++; if (bus.MispredCnt !== 32'd1) begin n_err++; $display("FAIL first_mcnt got %0d want 1", bus.MispredCnt); end
  endtask

  task automatic test_hysteresis();
    // outcome sequence after the first not-taken, with the expected prediction after each
    logic seq_tk [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic seq_pr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.PCF = 32'h40;
    drive(1'b1, 1'b0, BEQ, 1'b0, 32'h40, 32'h80, 1'b1, 32'h80);
    #1;
    n_cmp++; if (bus.MispredE !== 1'b1) begin n_err++; $display("FAIL hyst_mispred got %0b want 1", bus.MispredE); end
    n_cmp++; if (bus.RedirectPCE !== 32'h44) begin n_err++; $display("FAIL hyst_redirect got %h want 00000044", bus.RedirectPCE); end
    tick();
    idle_ex();
    #1;
    n_cmp++; if (bus.PredTakenF !== 1'b0) begin n_err++; $display("FAIL hyst_wnt got %0b want 0", bus.PredTakenF); end
    for (int k = 0; k < 7; k++) begin
      resolve(32'h40, seq_tk[k], 32'h80);
      #1;
      n_cmp++;
      if (bus.PredTakenF !== seq_pr[k]) begin
        n_err++; $display("FAIL hyst_step%0d got %0b want %0b", k, bus.PredTakenF, seq_pr[k]);
      end
    end
  endtask

  task automatic test_alias();
    resolve(32'h1040, 1'b1, 32'h2000);
    bus.PCF = 32'h40;
    #1;
    n_cmp++; if (bus.PredTakenF !== 1'b0) begin n_err++; $display("FAIL alias_old got %0b want 0", bus.PredTakenF); end
    n_cmp++; if (bus.PredTargetF !== 32'h44) begin n_err++; $display("FAIL alias_old_tgt got %h want 00000044", bus.PredTargetF); end
    bus.PCF = 32'h1040;
    #1;
    n_cmp++; if (bus.PredTakenF !== 1'b1) begin n_err++; $display("FAIL alias_new got %0b want 1", bus.PredTakenF); end
    n_cmp++; if (bus.PredTargetF !== 32'h2000) begin n_err++; $display("FAIL alias_new_tgt got %h want 00002000", bus.PredTargetF); end
  endtask

  task automatic test_stall();
    logic [31:0] b0, m0;
    b0 = m_bcnt;
    m0 = m_mcnt;
    drive(1'b1, 1'b1, BNE, 1'b1, 32'h200, 32'h300, 1'b0, 32'h204);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (bus.MispredE !== 1'b0) begin n_err++; $display("FAIL stall_mispred%0d got %0b want 0", k, bus.MispredE); end
      n_cmp++; if (bus.BranchCnt !== b0) begin n_err++; $display("FAIL stall_bcnt%0d got %0d want %0d", k, bus.BranchCnt, b0); end
      n_cmp++; if (bus.MispredCnt !== m0) begin n_err++; $display("FAIL stall_mcnt%0d got %0d want %0d", k, bus.MispredCnt, m0); end
      tick();
    end
    bus.StallE = 1'b0;
    #1;
    n_cmp++; if (bus.MispredE !== 1'b1) begin n_err++; $display("FAIL stall_release got %0b want 1", bus.MispredE); end
    n_cmp++; if (bus.RedirectPCE !== 32'h300) begin n_err++; $display("FAIL stall_redirect got %h want 00000300", bus.RedirectPCE); end
    tick();
    idle_ex();
    #1;
    n_cmp++; if (bus.MispredE !== 1'b0) begin n_err++; $display("FAIL stall_once got %0b want 0", bus.MispredE); end
    n_cmp++; if (bus.BranchCnt !== b0 + 32'd1) begin n_err++; $display("FAIL stall_bcnt_inc got %0d want %0d", bus.BranchCnt, b0 + 32'd1); end
    n_cmp++; if (bus.MispredCnt !== m0 + 32'd1) begin n_err++; $display("FAIL stall_mcnt_inc got %0d want %0d", bus.MispredCnt, m0 + 32'd1); end
  endtask

  task automatic test_same_index();
    bus.PCF = 32'h40;
    drive(1'b1, 1'b0, BEQ, 1'b1, 32'h40, 32'h90, 1'b0, 32'h44);
    #1;
    n_cmp++; if (bus.PredTakenF !== 1'b0) begin n_err++; $display("FAIL same_idx_old got %0b want 0", bus.PredTakenF); end
    tick();
    idle_ex();
    #1;
    n_cmp++; if (bus.PredTakenF !== 1'b1) begin n_err++; $display("FAIL same_idx_new got %0b want 1", bus.PredTakenF); end
    n_cmp++; if (bus.PredTargetF !== 32'h90) begin n_err++; $display("FAIL same_idx_tgt got %h want 00000090", bus.PredTargetF); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pcs [3] = '{32'h40, 32'h1040, 32'h200};
    CPU_RST = 1'b1;
    drive(1'b1, 1'b0, BGE, 1'b1, 32'h500, 32'h600, 1'b0, 32'h504);
    #1;
    n_cmp++; if (bus.MispredE !== 1'b0) begin n_err++; $display("FAIL rst_mispred got %0b want 0", bus.MispredE); end
    tick();
    CPU_RST = 1'b0;
    idle_ex();
    #1;
    n_cmp++; if (bus.BranchCnt !== 32'd0) begin n_err++; $display("FAIL rst_bcnt got %0d want 0", bus.BranchCnt); end
    n_cmp++; if (bus.MispredCnt !== 32'd0) begin n_err++; $display("FAIL rst_mcnt got %0d want 0", bus.MispredCnt); end
    foreach (pcs[k]) begin
      bus.PCF = pcs[k];
      #1;
      n_cmp++;
      if (bus.PredTakenF !== 1'b0 || bus.PredTargetF !== pcs[k] + 32'd4) begin
        n_err++; $display("FAIL rst_lookup pc=%h got %0b/%h want 0/%h", pcs[k], bus.PredTakenF, bus.PredTargetF, pcs[k] + 32'd4);
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] tags [4] = '{32'h0, 32'h1, 32'h2, 32'h10};
    return (tags[$urandom_range(0, 3)] << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic test_random();
    logic etk, br, mis;
    logic [31:0] etg, erd, pce, bt;
    logic mtk;
    logic [31:0] mtg;
    for (int n = 0; n < 600; n++) begin
      CPU_RST = ($urandom_range(0, 99) == 0);
      bus.PCF = rand_pc();
      pce = rand_pc();
      bt  = rand_pc() + 32'h4000;
      model_predict(pce, mtk, mtg);
      if ($urandom_range(0, 3) == 0) begin
        mtk = 1'($urandom_range(0, 1));
        mtg = ($urandom_range(0, 1) == 0) ? bt : pce + 32'd4;
      end
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) == 0),
            br_type_e'(3'($urandom_range(0, 6))), 1'($urandom_range(0, 1)),
            pce, bt, mtk, mtg);
      #1;
      model_predict(bus.PCF, etk, etg);
      model_ex(br, mis, erd);
      n_cmp++; if (bus.PredTakenF !== etk) begin n_err++; $display("FAIL rnd_pred n=%0d got %0b want %0b", n, bus.PredTakenF, etk); end
      n_cmp++; if (bus.PredTargetF !== etg) begin n_err++; $display("FAIL rnd_target n=%0d got %h want %h", n, bus.PredTargetF, etg); end
      n_cmp++; if (bus.MispredE !== mis) begin n_err++; $display("FAIL rnd_mispred n=%0d got %0b want %0b", n, bus.MispredE, mis); end
      if (mis) begin
        n_cmp++; if (bus.RedirectPCE !== erd) begin n_err++; $display("FAIL rnd_redirect n=%0d got %h want %h", n, bus.RedirectPCE, erd); end
      end
      n_cmp++; if (bus.BranchCnt !== m_bcnt) begin n_err++; $display("FAIL rnd_bcnt n=%0d got %0d want %0d", n, bus.BranchCnt, m_bcnt); end
      n_cmp++; if (bus.MispredCnt !== m_mcnt) begin n_err++; $display("FAIL rnd_mcnt n=%0d got %0d want %0d", n, bus.MispredCnt, m_mcnt); end
      tick();
    end
    CPU_RST = 1'b0;
    idle_ex();
  endtask

  initial begin
    idle_ex();
    bus.PCF = 32'h0;
    m_bcnt  = 32'h0;
    m_mcnt  = 32'h0;
    test_reset();
    test_first_taken();
    test_hysteresis();
    test_alias();
    test_stall();
    test_same_index();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters for the RV32 pipeline CPU.
- In IF it predicts taken/target for the fetch PC.
- In EX it takes the resolved BranchE from the branch-decision unit and does three things:
  - detects a mispredict;
  - drives the redirect PC consumed by the hazard unit (flush of ID and EX);
  - trains the table.
- It also keeps branch and mispredict statistics counters.

Parameters:
- IDX_W, 6, index width; table has 2^IDX_W entries.
- CNT_W, 32, width of the statistics counters.

Ports:
- CPU_CLK  in  1  core clock; all state updates on the rising edge.
- CPU_RST  in  1  synchronous, active-high reset.
- PCF  in  32  fetch-stage PC.
- PredTakenF  out  1  prediction for PCF; combinational.
- PredTargetF  out  32  predicted target for PCF; combinational.
- ValidE  in  1  EX slot holds a real (non-flushed) instruction.
- StallE  in  1  EX stage held this cycle.
- BranchTypeE  in  3  branch type code from the shared package; NOBRANCH means not a branch.
- BranchE  in  1  resolved outcome from the branch-decision unit.
- PCE  in  32  PC of the EX-stage instruction.
- BrTargetE  in  32  computed branch target.
- PredTakenE  in  1  prediction carried down the pipeline with the instruction.
- PredTargetE  in  32  predicted target carried down the pipeline.
- MispredE  out  1  mispredict; hazard unit flushes ID and EX and loads RedirectPCE.
- RedirectPCE  out  32  correct next PC.
- BranchCnt  out  CNT_W  number of resolved branches.
- MispredCnt  out  CNT_W  number of mispredicts.

Behaviour:
- Index and tag:
  - idx = PC[IDX_W+1:2], tag = PC[31:IDX_W+2].
  - Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Lookup (combinational):
  - hit = valid[idx] && tag match.
  - PredTakenF = hit && ctr[1].
  - PredTargetF = target when PredTakenF, else PCF+4.
- Resolve: brE = ValidE && BranchTypeE != NOBRANCH && !StallE.
- Mispredict (combinational, gated by brE):
  - BranchE=1 and (PredTakenE=0 or PredTargetE != BrTargetE) -> MispredE=1, RedirectPCE = BrTargetE.
  - BranchE=0 and PredTakenE=1 -> MispredE=1, RedirectPCE = PCE+4.
  - Otherwise MispredE=0 and RedirectPCE = PCE+4 (don't-care).
  - MispredE is 0 whenever brE=0.
- Training (registered, only when brE=1, entry at PCE index):
  - On hit, BranchE=1: ctr saturating-increments (max 2'b11); target <= BrTargetE.
  - On hit, BranchE=0: ctr saturating-decrements (min 2'b00); entry stays valid.
  - On miss, BranchE=1: allocate with valid=1, tag and target from PCE/BrTargetE, ctr=2'b10; this overwrites any conflicting entry.
  - On miss, BranchE=0: no write.
- Same cycle, same index (PCF and PCE): lookup returns pre-update contents; the write is visible the next cycle.
- Statistics:
  - BranchCnt increments when brE=1.
  - MispredCnt increments when brE && MispredE.
  - Both wrap modulo 2^CNT_W.
- StallE=1: no training, no counting, MispredE=0. The same instruction resolves once, when the stall releases.
- Reset, applied at any point:
  - Next edge clears all valid bits and both counters.
  - ctr and target are don't-care.
  - While CPU_RST=1, MispredE is forced 0.
  - After reset, every lookup misses, so PredTakenF=0 and PredTargetF=PCF+4.
- Latency:
  - Prediction: 0 cycles.
  - Training: visible to a lookup 1 cycle after the EX resolve edge.
- Non-branch instructions in EX (jal/jalr) are outside this block's scope and are never trained.

Decomposition:
- Shared package / Parameters.v holds:
  - branch type codes: NOBRANCH=0, BEQ=1, BNE=2, BLT=3, BLTU=4, BGE=5, BGEU=6;
  - counter constants: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
- One natural sub-module, btb_sat_counter: the 2-bit next-state function (inc/dec with saturation). The table and update control stay in the top.

Test Plan:
- Reset, then PCF=0x0000_0040 -> PredTakenF=0, PredTargetF=0x0000_0044; BranchCnt=0, MispredCnt=0.
- First taken branch: PCE=0x40, BranchTypeE=BEQ, BranchE=1, BrTargetE=0x80, PredTakenE=0 -> MispredE=1, RedirectPCE=0x80. Next cycle PCF=0x40 -> PredTakenF=1, PredTargetF=0x80.
- Hysteresis: resolve 0x40 not-taken with PredTakenE=1 -> MispredE=1, RedirectPCE=0x44, ctr 10->01. Then PCF=0x40 -> PredTakenF=0. Two further taken resolves -> ctr=11. Then three not-taken resolves -> ctr=00 (saturates); entry stays valid.
- Alias eviction with IDX_W=6: 0x40 trained taken, then 0x1040 (same idx, new tag) resolves taken -> entry replaced. PCF=0x40 now misses -> PredTakenF=0.
- StallE=1 for 3 cycles with BNE, BranchE=1, PredTakenE=0 -> MispredE=0, counters unchanged. On the cycle StallE drops -> MispredE=1 once; BranchCnt and MispredCnt each +1.
- Same-index collision: PCF=PCE=0x40 with a training write -> PCF prediction uses old entry, new entry seen next cycle. Separately, CPU_RST=1 mid-run -> all lookups miss and counters read 0 after that edge.
